capture_ctrl: RTL and testbench

Consumer of the trigger block's trig_valid/trig_pos. Delays the 32-channel x 8-sample word by one cycle to align with the registered trigger output. Writes words into a circular sample RAM with a pre-trigger depth and a post-trigger depth. On completion, reports the trigger location and the valid capture window for the readout logic.

---
 rtl/capture_ctrl.sv | 146 ++++++++++++++
 tb/tb_capture_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for the circular sample RAM. Keeps pre-trigger history, stores the
// trigger word and the post-trigger words, then reports where the valid window sits.

module capture_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VEC_W-1:0] d,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else     q <= d;
endmodule

module capture_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_words,
  input  logic [ADDR_W-1:0] post_words,
  input  logic [31:0][7:0]  wr_states,
  input  logic              trig_valid,
  input  logic [2:0]        trig_pos,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0][7:0]  mem_wdata,
  output logic [2:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [2:0]        trig_sub,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W:0]   cap_len
);
  localparam int NUM_LANES = 32;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0, PRETRIG = 3'd1, WAIT_TRIG = 3'd2, POSTTRIG = 3'd3, DONE = 3'd4
  } state_t;

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] wr_ptr, fill_cnt, post_cnt, pre_eff, post_eff;
  logic [ADDR_W-1:0] ptr_nxt, fill_nxt, post_nxt, pre_lim, pre_clamp, trig_src;
  logic              capturing, enter_done;

  // One-cycle delay so each word lines up with the registered trigger that refers to it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    capture_lane #(.VEC_W(VEC_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .d   (wr_states[i]),
      .q   (mem_wdata[i])
    );
  end

  // post_words can never exceed DEPTH-1, so only pre needs clamping: DEPTH-1-post == ~post.
  assign pre_lim   = ~post_words;
  assign pre_clamp = (pre_words > pre_lim) ? pre_lim : pre_words;

  assign ptr_nxt   = wr_ptr + 1'b1;
  assign fill_nxt  = fill_cnt + 1'b1;
  assign post_nxt  = post_cnt + 1'b1;
  assign capturing = (st_q == PRETRIG && pre_eff != '0) || st_q == WAIT_TRIG || st_q == POSTTRIG;
  assign trig_src  = (st_q == WAIT_TRIG) ? wr_ptr : trig_addr;
  assign enter_done = (st_d == DONE) && (st_q != DONE);

  assign state    = st_q;
  assign mem_we   = capturing;
  assign mem_addr = capturing ? wr_ptr : '0;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE, DONE: if (arm) st_d = PRETRIG;
      PRETRIG:    if (!capturing || fill_nxt == pre_eff) st_d = WAIT_TRIG;
      WAIT_TRIG:  if (trig_valid) st_d = (post_eff == '0) ? DONE : POSTTRIG;
      POSTTRIG:   if (post_nxt == post_eff) st_d = DONE;
      default:    st_d = IDLE;
    endcase
    if (abort) st_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      pre_eff    <= '0;
      post_eff   <= '0;
      trig_addr  <= '0;
      trig_sub   <= '0;
      start_addr <= '0;
      cap_len    <= '0;
      done       <= 1'b0;
    end else begin
      st_q <= st_d;
      if (abort) begin
        trig_addr  <= '0;
        trig_sub   <= '0;
        start_addr <= '0;
        cap_len    <= '0;
        done       <= 1'b0;
      end else begin
        case (st_q)
          IDLE, DONE: if (arm) begin
            post_eff   <= post_words;
            pre_eff    <= pre_clamp;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            start_addr <= '0;
            cap_len    <= '0;
            done       <= 1'b0;
          end
          PRETRIG: if (capturing) begin
            wr_ptr   <= ptr_nxt;
            fill_cnt <= fill_nxt;
          end
          WAIT_TRIG: begin
            wr_ptr <= ptr_nxt;
            if (trig_valid) begin
              trig_addr <= wr_ptr;
              trig_sub  <= trig_pos;
              post_cnt  <= '0;
            end
          end
          POSTTRIG: begin
            wr_ptr   <= ptr_nxt;
            post_cnt <= post_nxt;
          end
          default: ;
        endcase
        if (enter_done) begin
          done       <= 1'b1;
          start_addr <= trig_src - pre_eff;
          cap_len    <= {1'b0, pre_eff} + {1'b0, post_eff} + (ADDR_W+1)'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl: a cycle-indexed model of the capture phases plus a
// shadow RAM that records what the DUT writes.

module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int D  = 1 << AW;

  logic             clk = 1'b0;
  logic             rst, arm, abort, trig_valid;
  logic [AW-1:0]    pre_words, post_words, mem_addr, trig_addr, start_addr;
  logic [31:0][7:0] wr_states, mem_wdata;
  logic [2:0]       trig_pos, state, trig_sub;
  logic             mem_we, done;
  logic [AW:0]      cap_len;
  logic [31:0][7:0] ram [D];
  int               total = 0, bad = 0;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_words(pre_words), .post_words(post_words), .wr_states(wr_states),
    .trig_valid(trig_valid), .trig_pos(trig_pos), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .state(state), .done(done), .trig_addr(trig_addr),
    .trig_sub(trig_sub), .start_addr(start_addr), .cap_len(cap_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  function automatic logic [31:0][7:0] rnd_word();
    logic [31:0][7:0] w;
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    return w;
  endfunction

  // Model: cycle k after the arm edge is PRETRIG for k<=max(pre,1), WAIT_TRIG up to the
  // first trigger seen after that, POSTTRIG for post more cycles, then DONE.
  task automatic do_capture(input string nm, input int pre, input int post,
                            input int early_k, input int trig_k);
    int pe, pr, P, kacc, nwr, exp_st, exp_ta, a;
    logic exp_we;
    logic [2:0] exp_sub;
    logic [31:0][7:0] prev, cur, trig_word;
    logic [31:0][7:0] mram [D];
    pe = (post > D-1) ? D-1 : post;
    pr = (pre > D-1-pe) ? D-1-pe : pre;
    P = (pr == 0) ? 1 : pr;
    kacc = (early_k > P) ? early_k : trig_k;
    nwr = 0; exp_ta = 0; exp_sub = 3'd0; trig_word = '0;
    @(negedge clk);
    pre_words = AW'(pre); post_words = AW'(post); arm = 1'b1; trig_valid = 1'b0;
    prev = rnd_word(); wr_states = prev;
    @(negedge clk);
    arm = 1'b0;
    for (int k = 1; k <= kacc + pe + 2; k++) begin
      exp_st = (k <= P) ? 1 : (k <= kacc) ? 2 : (k <= kacc + pe) ? 3 : 4;
      exp_we = (exp_st == 1 && pr > 0) || exp_st == 2 || exp_st == 3;
      total++; if (state !== 3'(exp_st)) begin bad++; $display("FAIL %s state k=%0d got=%0d exp=%0d", nm, k, state, exp_st); end
      total++; if (mem_we !== exp_we) begin bad++; $display("FAIL %s mem_we k=%0d got=%b exp=%b", nm, k, mem_we, exp_we); end
      if (exp_we) begin
        total++; if (mem_addr !== AW'(nwr % D)) begin bad++; $display("FAIL %s mem_addr k=%0d got=%0d exp=%0d", nm, k, mem_addr, nwr % D); end
      end
      total++; if (mem_wdata !== prev) begin bad++; $display("FAIL %s mem_wdata k=%0d got=%h exp=%h", nm, k, mem_wdata, prev); end
      total++; if (done !== (exp_st == 4)) begin bad++; $display("FAIL %s done k=%0d got=%b exp=%b", nm, k, done, exp_st == 4); end
      if (exp_st == 4) begin
        total++; if (trig_addr !== AW'(exp_ta)) begin bad++; $display("FAIL %s trig_addr got=%0d exp=%0d", nm, trig_addr, exp_ta); end
        total++; if (trig_sub !== exp_sub) begin bad++; $display("FAIL %s trig_sub got=%0d exp=%0d", nm, trig_sub, exp_sub); end
        total++; if (start_addr !== AW'(((exp_ta - pr) % D + D) % D)) begin bad++; $display("FAIL %s start_addr got=%0d exp=%0d", nm, start_addr, ((exp_ta - pr) % D + D) % D); end
        total++; if (cap_len !== (AW+1)'(pr + pe + 1)) begin bad++; $display("FAIL %s cap_len got=%0d exp=%0d", nm, cap_len, pr + pe + 1); end
      end else begin
        total++; if (start_addr !== '0 || cap_len !== '0) begin bad++; $display("FAIL %s window_idle k=%0d got=%0d/%0d exp=0/0", nm, k, start_addr, cap_len); end
      end
      if (k == kacc) begin exp_ta = nwr % D; trig_word = prev; end
      if (exp_we) begin mram[nwr % D] = prev; nwr++; end
      cur = rnd_word(); wr_states = cur;
      trig_valid = (k == early_k || k == trig_k);
      trig_pos = 3'($urandom_range(0, 7));
      if (k == kacc) exp_sub = trig_pos;
      pre_words = AW'($urandom); post_words = AW'($urandom);
      @(negedge clk);
      prev = cur;
    end
    trig_valid = 1'b0;
    total++; if (ram[exp_ta] !== trig_word) begin bad++; $display("FAIL %s trig_word got=%h exp=%h", nm, ram[exp_ta], trig_word); end
    for (int i = 0; i < pr + pe + 1; i++) begin
      a = ((exp_ta - pr + i) % D + D) % D;
      total++; if (ram[a] !== mram[a]) begin bad++; $display("FAIL %s window[%0d] got=%h exp=%h", nm, i, ram[a], mram[a]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_valid = 1'b1; trig_pos = 3'd7;
    pre_words = '1; post_words = '1; wr_states = rnd_word();
    repeat (2) @(negedge clk);
    total++; if (state !== 3'd0 || done !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset ctrl got=%0d/%b/%b exp=0/0/0", state, done, mem_we); end
    total++; if (mem_wdata !== '0 || mem_addr !== '0) begin bad++; $display("FAIL reset data got=%h/%0d exp=0/0", mem_wdata, mem_addr); end
    total++; if (trig_addr !== '0 || trig_sub !== '0 || start_addr !== '0 || cap_len !== '0) begin bad++; $display("FAIL reset window got=%0d/%0d/%0d/%0d exp=0", trig_addr, trig_sub, start_addr, cap_len); end
    rst = 1'b0; trig_valid = 1'b0;
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_idle got=%0d exp=0", state); end
  endtask

  task automatic test_basic();     do_capture("basic", 3, 4, 0, 10);  endtask
  task automatic test_alignment(); do_capture("align", 2, 3, 0, 6);   endtask
  task automatic test_wrap();      do_capture("wrap", 5, 2, 0, 41);   endtask
  task automatic test_clamp();     do_capture("clamp", 15, 15, 0, 5); endtask

  task automatic test_pretrig_ignore();
    do_capture("pre_ign", 6, 3, 2, 12);
    do_capture("zero", 0, 0, 0, 3);
  endtask

  task automatic test_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (state !== 3'd0 || done !== 1'b0 || start_addr !== '0 || cap_len !== '0) begin bad++; $display("FAIL abort_done got=%0d/%b/%0d/%0d exp=0", state, done, start_addr, cap_len); end
    pre_words = AW'(2); post_words = AW'(6); arm = 1'b1; trig_valid = 1'b0;
    @(negedge clk); arm = 1'b0;
    repeat (2) @(negedge clk);
    trig_valid = 1'b1; trig_pos = 3'd5;
    @(negedge clk); trig_valid = 1'b0;
    @(negedge clk);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL abort_pre got=%0d exp=3", state); end
    abort = 1'b1; arm = 1'b1;
    @(negedge clk); abort = 1'b0; arm = 1'b0;
    total++; if (state !== 3'd0 || done !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL abort_post got=%0d/%b/%b exp=0/0/0", state, done, mem_we); end
    total++; if (trig_addr !== '0 || trig_sub !== '0 || start_addr !== '0 || cap_len !== '0) begin bad++; $display("FAIL abort_clear got=%0d/%0d/%0d/%0d exp=0", trig_addr, trig_sub, start_addr, cap_len); end
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL abort_hold got=%0d exp=0", state); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); pre_words = AW'(3); post_words = AW'(4); arm = 1'b1; trig_valid = 1'b0;
    @(negedge clk); arm = 1'b0;
    repeat (3) @(negedge clk);
    trig_valid = 1'b1; trig_pos = 3'd6;
    @(negedge clk); trig_valid = 1'b0; wr_states = rnd_word();
    total++; if (state !== 3'd3 || trig_addr !== AW'(3)) begin bad++; $display("FAIL arst_pre got=%0d/%0d exp=3/3", state, trig_addr); end
    #2 rst = 1'b1;
    #1;
    total++; if (state !== 3'd0 || mem_we !== 1'b0 || done !== 1'b0 || mem_addr !== '0) begin bad++; $display("FAIL arst_ctrl got=%0d/%b/%b/%0d exp=0", state, mem_we, done, mem_addr); end
    total++; if (mem_wdata !== '0 || trig_addr !== '0 || trig_sub !== '0 || start_addr !== '0 || cap_len !== '0) begin bad++; $display("FAIL arst_data got=%h/%0d/%0d exp=0", mem_wdata, trig_addr, trig_sub); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (state !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL arst_idle got=%0d/%b exp=0/0", state, mem_we); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      do_capture("rand", $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(1, 16), 17 + $urandom_range(0, 10));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alignment();
    test_wrap();
    test_clamp();
    test_pretrig_ignore();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
